// File: rtl/ram_march_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_bist_pkg
//  Description : Shared types, March C- element tables and background
//                constants for the RAM March BIST controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_march_bist_pkg;

    // Controller states. STEP is kept as a named state so the address/element
    // advance has a name in the encoding, but the advance itself is folded
    // into the last cycle of each address and costs no cycle of its own.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // March element indices
    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // Background selectors; expanded to DATA_W bits by the user
    localparam logic BG_ZERO = 1'b0;
    localparam logic BG_ONE  = 1'b1;

    // Per-element tables, bit i describes element Mi:
    //   M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
    localparam logic [5:0] ELEM_UP        = 6'b100111;
    localparam logic [5:0] ELEM_HAS_READ  = 6'b111110;
    localparam logic [5:0] ELEM_READ_BG   = 6'b010100;
    localparam logic [5:0] ELEM_HAS_WRITE = 6'b011111;
    localparam logic [5:0] ELEM_WRITE_BG  = 6'b001010;

    function automatic logic elem_is_up(input logic [2:0] e);
        return ELEM_UP[e];
    endfunction

    function automatic logic elem_has_read(input logic [2:0] e);
        return ELEM_HAS_READ[e];
    endfunction

    function automatic logic elem_has_write(input logic [2:0] e);
        return ELEM_HAS_WRITE[e];
    endfunction

    function automatic logic elem_read_bg(input logic [2:0] e);
        return ELEM_READ_BG[e];
    endfunction

    function automatic logic elem_write_bg(input logic [2:0] e);
        return ELEM_WRITE_BG[e];
    endfunction

    // First operation performed at each address of an element
    function automatic state_t elem_first_state(input logic [2:0] e);
        return elem_has_read(e) ? ST_READ : ST_WRITE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_march_bist_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_addr_gen
//  Description : Up/down address counter for the March BIST. Load selects the
//                direction and starts at the first address of that direction;
//                enable steps one address; last flags the terminal address.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_march_addr_gen
    import ram_march_bist_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_up,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_INC = 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              up_q, up_d;

    // Next address: load wins over enable; no wrap, the caller stops at last
    always_comb begin
        addr_d = addr_q;
        up_d   = up_q;
        if (load) begin
            up_d   = load_up;
            addr_d = load_up ? '0 : '1;
        end else if (en) begin
            addr_d = up_q ? (addr_q + ADDR_INC) : (addr_q - ADDR_INC);
        end
    end

    // Counter and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            up_q   <= 1'b1;
        end else begin
            addr_q <= addr_d;
            up_q   <= up_d;
        end
    end

    // Terminal address depends only on the latched direction, never on load
    assign last = up_q ? (addr_q == '1) : (addr_q == '0);
    assign addr = addr_q;

endmodule
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_bist
//  Description : March C- BIST controller for a single-port RAM. Drives the
//                RAM through registered data/address/write-enable, checks the
//                read data and reports pass/fail with first-failure capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_march_bist
    import ram_march_bist_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [7:0]        fail_count,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read
);

    // Index of the READ cycle on which mem_read is valid and compared
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);
    localparam logic       HALT     = (STOP_ON_FAIL != 0);

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [1:0]        lat_q, lat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [7:0]        fail_count_q, fail_count_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;

    logic              ag_load;
    logic              ag_load_up;
    logic              ag_en;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_last;
    logic              step;
    logic              miscompare;
    logic [DATA_W-1:0] expect_data;

    ram_march_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (ag_load),
        .load_up (ag_load_up),
        .en      (ag_en),
        .addr    (ag_addr),
        .last    (ag_last)
    );

    // Next-state, result capture and registered RAM-interface decode
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        lat_d        = lat_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        fail_count_d = fail_count_q;
        fail_elem_d  = fail_elem_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        ag_load      = 1'b0;
        ag_en        = 1'b0;
        step         = 1'b0;
        miscompare   = 1'b0;
        expect_data  = {DATA_W{elem_read_bg(elem_q)}};

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = elem_first_state(M0);
                    elem_d       = M0;
                    lat_d        = 2'd0;
                    ag_load      = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    fail_count_d = 8'd0;
                    fail_elem_d  = 3'd0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                end
            end
            ST_WRITE: begin
                // A write is always the last operation at an address
                step = 1'b1;
            end
            ST_READ: begin
                if (lat_q != LAT_LAST) begin
                    lat_d = lat_q + 2'd1;
                end else begin
                    lat_d = 2'd0;
                    if (mem_read != expect_data) begin
                        miscompare = 1'b1;
                        if (fail_count_q != 8'hFF) begin
                            fail_count_d = fail_count_q + 8'd1;
                        end
                        if (!fail_q) begin
                            fail_d      = 1'b1;
                            fail_elem_d = elem_q;
                            fail_addr_d = ag_addr;
                            fail_data_d = mem_read;
                        end
                    end
                    if (miscompare && HALT) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (elem_has_write(elem_q)) begin
                        state_d = ST_WRITE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Folded STEP: next address, next element, or end of test
        if (step) begin
            if (!ag_last) begin
                ag_en   = 1'b1;
                state_d = elem_first_state(elem_q);
            end else if (elem_q == M5) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                elem_d  = elem_q + 3'd1;
                ag_load = 1'b1;
                state_d = elem_first_state(elem_d);
            end
        end

        ag_load_up = elem_is_up(elem_d);

        // RAM outputs are registered, so they follow the state being entered
        mem_we_d = (state_d == ST_WRITE);
        if (state_d == ST_WRITE) begin
            mem_data_d = {DATA_W{elem_write_bg(elem_d)}};
        end
    end

    // Controller state and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            elem_q       <= M0;
            lat_q        <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_count_q <= 8'd0;
            fail_elem_q  <= 3'd0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            lat_q        <= lat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_count_q <= fail_count_d;
            fail_elem_q  <= fail_elem_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign fail             = fail_q;
    assign fail_count       = fail_count_q;
    assign fail_elem        = fail_elem_q;
    assign fail_addr        = fail_addr_q;
    assign fail_data        = fail_data_q;
    assign mem_data         = mem_data_q;
    assign mem_addr         = ag_addr;
    assign mem_write_enable = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_march_bist
//  Description : Bench for ram_march_bist. Three instances (default, run-to-
//                completion, zero read latency) each drive a behavioural RAM
//                with an optional stuck-at bit; results are predicted by a
//                March C- reference model and checked by a done-monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_march_bist;

    localparam int NI = 3;

    typedef struct {
        int inst;
        int fail;
        int cnt;
        int elem;
        int addr;
        int data;
        int cycles;
        int writes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start [NI];

    wire        busy       [NI];
    wire        done       [NI];
    wire        fail       [NI];
    wire [7:0]  fail_count [NI];
    wire [2:0]  fail_elem  [NI];
    wire [5:0]  fail_addr  [NI];
    wire [7:0]  fail_data  [NI];
    wire [7:0]  mem_data   [NI];
    wire [5:0]  mem_addr   [NI];
    wire        mem_we     [NI];
    wire [7:0]  mem_read   [NI];

    logic       fault_en;
    logic [5:0] fault_addr;
    logic [2:0] fault_bit;
    logic       fault_val;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] faulty(input logic [7:0] v, input logic [5:0] a,
                                          input logic en, input logic [5:0] fa,
                                          input logic [2:0] fb, input logic fv);
        logic [7:0] r;
        r = v;
        if (en && a == fa) r[fb] = fv;
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT  = (g == 2) ? 0 : 1;
        localparam int STOP = (g == 1) ? 0 : 1;
        logic [7:0] ram [64];
        logic [7:0] rd_q;

        ram_march_bist #(
            .ADDR_W(6), .DATA_W(8), .RD_LAT(LAT), .STOP_ON_FAIL(STOP)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .fail             (fail[g]),
            .fail_count       (fail_count[g]),
            .fail_elem        (fail_elem[g]),
            .fail_addr        (fail_addr[g]),
            .fail_data        (fail_data[g]),
            .mem_data         (mem_data[g]),
            .mem_addr         (mem_addr[g]),
            .mem_write_enable (mem_we[g]),
            .mem_read         (mem_read[g])
        );

        always @(posedge clk) begin
            if (mem_we[g]) ram[mem_addr[g]] <= mem_data[g];
            rd_q <= faulty(ram[mem_addr[g]], mem_addr[g], fault_en, fault_addr, fault_bit, fault_val);
        end

        assign mem_read[g] = (LAT == 0)
            ? faulty(ram[mem_addr[g]], mem_addr[g], fault_en, fault_addr, fault_bit, fault_val)
            : rd_q;
    end

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d", name, inst, act, exp);
        end
    endtask

    // March C- reference: walk the elements over an array memory with the
    // same stuck bit, counting cycles and writes and recording the first miss
    function automatic exp_t ref_model(input int inst, input int lat, input bit stop,
                                       input logic en, input logic [5:0] fa,
                                       input logic [2:0] fb, input logic fv);
        int         up [6] = '{1, 1, 1, 0, 0, 1};
        int         rd [6] = '{-1, 0, 1, 0, 1, 0};
        int         wr [6] = '{0, 1, 0, 1, 0, -1};
        logic [7:0] m  [64];
        logic [7:0] v;
        exp_t       e;
        int         a;
        e = '{inst, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 64; k++) m[k] = 8'h00;
        for (int el = 0; el < 6; el++) begin
            for (int k = 0; k < 64; k++) begin
                a = (up[el] != 0) ? k : 63 - k;
                if (rd[el] >= 0) begin
                    e.cycles += lat + 1;
                    v = faulty(m[a], 6'(a), en, fa, fb, fv);
                    if (v != ((rd[el] != 0) ? 8'hFF : 8'h00)) begin
                        if (e.cnt < 255) e.cnt++;
                        if (e.fail == 0) begin
                            e.fail = 1;
                            e.elem = el;
                            e.addr = a;
                            e.data = int'(v);
                        end
                        if (stop) return e;
                    end
                end
                if (wr[el] >= 0) begin
                    e.cycles += 1;
                    e.writes += 1;
                    m[a] = (wr[el] != 0) ? 8'hFF : 8'h00;
                end
            end
        end
        return e;
    endfunction

    // Monitor: per-instance activity counters, checked against the queue on done
    int   busy_cyc [NI];
    int   we_cyc   [NI];
    int   bad_inv  [NI];
    logic done_prev[NI];

    initial begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            busy_cyc[i] = 0; we_cyc[i] = 0; bad_inv[i] = 0; done_prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    busy_cyc[i] = 0; we_cyc[i] = 0; bad_inv[i] = 0; done_prev[i] = 1'b0;
                end else begin
                    if (busy[i]) busy_cyc[i]++;
                    if (mem_we[i]) begin
                        we_cyc[i]++;
                        if (!busy[i]) bad_inv[i] = 1;
                    end
                    if (busy[i] && done[i]) bad_inv[i] = 1;
                    if (done[i] && !done_prev[i]) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_done inst%0d: got done with %0d expected results pending", i, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("done_inst",   i, i,                 e.inst);
                            chk("fail",        i, int'(fail[i]),     e.fail);
                            chk("fail_count",  i, int'(fail_count[i]), e.cnt);
                            chk("fail_elem",   i, int'(fail_elem[i]), e.elem);
                            chk("fail_addr",   i, int'(fail_addr[i]), e.addr);
                            chk("fail_data",   i, int'(fail_data[i]), e.data);
                            chk("busy_cycles", i, busy_cyc[i],       e.cycles);
                            chk("write_cycles",i, we_cyc[i],         e.writes);
                            chk("we_busy_done_invariant", i, bad_inv[i], 0);
                        end
                        busy_cyc[i] = 0; we_cyc[i] = 0; bad_inv[i] = 0;
                    end
                    done_prev[i] = done[i];
                end
            end
        end
    end

    task automatic pulse(input int inst);
        @(negedge clk);
        start[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
    endtask

    task automatic wait_empty();
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d results pending expected %0d", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic set_fault(input logic en, input logic [5:0] fa, input logic [2:0] fb, input logic fv);
        fault_en = en; fault_addr = fa; fault_bit = fb; fault_val = fv;
    endtask

    task automatic push_exp(input int inst);
        exp_q.push_back(ref_model(inst, (inst == 2) ? 0 : 1, inst != 1,
                                  fault_en, fault_addr, fault_bit, fault_val));
    endtask

    task automatic run(input int inst);
        push_exp(inst);
        pulse(inst);
        wait_empty();
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, "_busy"},       i, int'(busy[i]),       0);
        chk({tag, "_done"},       i, int'(done[i]),       0);
        chk({tag, "_fail"},       i, int'(fail[i]),       0);
        chk({tag, "_fail_count"}, i, int'(fail_count[i]), 0);
        chk({tag, "_fail_elem"},  i, int'(fail_elem[i]),  0);
        chk({tag, "_fail_addr"},  i, int'(fail_addr[i]),  0);
        chk({tag, "_fail_data"},  i, int'(fail_data[i]),  0);
        chk({tag, "_mem_data"},   i, int'(mem_data[i]),   0);
        chk({tag, "_mem_addr"},   i, int'(mem_addr[i]),   0);
        chk({tag, "_mem_we"},     i, int'(mem_we[i]),     0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        set_fault(1'b0, 6'h00, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) chk_zero("reset", i);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fault-free pass at defaults
        run(0);
        // Bit 3 of 0x15 stuck at 0, halting and run-to-completion
        set_fault(1'b1, 6'h15, 3'd3, 1'b0);
        run(0);
        run(1);
        set_fault(1'b0, 6'h00, 3'd0, 1'b0);

        // Reset in the middle of a run, then a clean run
        pulse(0);
        repeat (399) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_zero("midrun_reset", 0);
        @(negedge clk);
        #1 rst = 1'b0;
        run(0);

        // A second start while busy is ignored
        push_exp(0);
        pulse(0);
        repeat (97) @(negedge clk);
        pulse(0);
        wait_empty();

        // Zero read latency against a combinational read
        run(2);

        // Random stuck-at faults across all three configurations
        for (int r = 0; r < 9; r++) begin
            set_fault($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            run(r % NI);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of the 64x8 single-port RAM.
- Drives the RAM data, address and write-enable, and checks the read-data output.
- Runs a March C- sequence on one start pulse and reports pass/fail plus the first failing location.
- Used at bring-up and in the regression bench before the RAM is handed to functional logic.

Parameters:
- ADDR_W, 6: RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: cycles from address presentation to valid read data; legal values 0..3.
- STOP_ON_FAIL, 1: 1 = halt on first miscompare; 0 = run to completion and count errors.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- busy  out  1  high while the test runs.
- done  out  1  high from test end until the next accepted start.
- fail  out  1  sticky miscompare flag; valid while done=1.
- fail_count  out  8  saturating count of miscompares.
- fail_elem  out  3  March element index (0..5) of the first failure.
- fail_addr  out  ADDR_W  address of the first failure.
- fail_data  out  DATA_W  data read at the first failure.
- mem_data  out  DATA_W  RAM write data.
- mem_addr  out  ADDR_W  RAM address.
- mem_write_enable  out  1  RAM write enable.
- mem_read  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, active-high): every output to 0, FSM to IDLE. Mid-run reset clears mem_write_enable in the same instant. No partial results are kept.
- Background values: ZERO = all 0s, ONE = all 1s.
- March elements:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Up elements run address 0 to DEPTH-1; down elements run DEPTH-1 to 0. The address counter has no wrap; element end is detected on the terminal address.
- FSM states: IDLE, WRITE, READ, STEP, DONE.
  - IDLE/DONE: start=1 clears all fail outputs and done, sets busy the next cycle, enters M0 at address 0.
  - WRITE: one cycle; mem_write_enable=1, mem_data = element write value.
  - READ: RD_LAT+1 cycles with mem_addr held and write enable 0. mem_read is compared on the last READ cycle. For r-then-w elements, WRITE follows READ at the same address.
  - STEP: advance the address, or on the terminal address advance the element. After M5 the FSM enters DONE: busy=0, done=1.
- STEP is folded into the last cycle of an address (zero extra cycles).
- Cycles per address:
  - M0: 1
  - M1..M4: RD_LAT+2
  - M5: RD_LAT+1
- Total run length at default parameters: 64 + 256*3 + 64*2 = 960 cycles from the first busy cycle to done.
- Miscompare handling:
  - Increment fail_count, saturating at 255.
  - On the first miscompare only: set fail and capture fail_elem, fail_addr and fail_data.
  - STOP_ON_FAIL=1: go straight to DONE the next cycle.
- start while busy is ignored.
- mem_* outputs are registered; mem_write_enable is never high outside WRITE.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WRITE, READ, STEP, DONE)
  - element index constants M0..M5
  - per-element direction, read-expect and write-value tables
  - ZERO/ONE background constants
- One natural sub-module: ram_march_addr_gen. It is an up/down address counter with load, enable and a terminal-address flag.

Test Plan:
- Fault-free behavioural RAM, defaults, start pulse → busy 960 cycles, then done=1, fail=0, fail_count=0.
- Bit 3 of address 0x15 stuck at 0 → fail=1, fail_elem=2, fail_addr=0x15, fail_data=0xF7, fail_count=1. Halt is immediate, so done arrives well before 960 cycles.
- Same fault with STOP_ON_FAIL=0 → full 960-cycle run, fail_count=2 (M2 and M4 r1 reads), first-failure fields unchanged.
- rst asserted at cycle 400 of a run → all outputs 0 asynchronously, FSM in IDLE. A new start then gives a clean 960-cycle pass.
- start pulsed again at cycle 100 of a run → ignored; run still ends at cycle 960 with a single done.
- RD_LAT=0 with a combinational-read model → total 640 cycles, pass. Check that mem_write_enable never overlaps a READ compare cycle.
